// File: rtl/mpeg_mv_pkg.sv
// ---------------------------------------------------------------------------
// mpeg_mv_pkg
// Shared types and constants for MPEG-2 dual-prime dmvector decoding.
//   state_t        : sequencer FSM states (IDLE, DEC_H, DEC_V, OUT)
//   DMV_*          : 2-bit two's-complement dmvector values
//   LEN_*          : dmvector code lengths in bits
//   is_decode_state: true in the states that pull bits from the shifter
// ---------------------------------------------------------------------------
package mpeg_mv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DEC_H = 2'd1,
    DEC_V = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam logic signed [1:0] DMV_ZERO = 2'sb00;
  localparam logic signed [1:0] DMV_POS  = 2'sb01;
  localparam logic signed [1:0] DMV_NEG  = 2'sb11;

  localparam logic [1:0] LEN_NONE  = 2'd0;
  localparam logic [1:0] LEN_SHORT = 2'd1;
  localparam logic [1:0] LEN_LONG  = 2'd2;

  function automatic logic is_decode_state(input state_t s);
    return (s == DEC_H) || (s == DEC_V);
  endfunction

endpackage

// File: rtl/dmv_pair_sequencer_if.sv
// ---------------------------------------------------------------------------
// dmv_pair_sequencer_if
// Bundles the parser start request, the bitstream shifter handshake and the
// predictor output handshake of the dmvector pair sequencer.
//   start       : decode-request pulse from the macroblock parser
//   busy        : sequencer not idle
//   bs_valid    : shifter holds at least 2 valid bits
//   bs_bits     : next two bits, bs_bits[1] earliest
//   bs_consume  : bits consumed this cycle (0..2)
//   dmv_h/dmv_v : decoded dmvector pair (signed, -1/0/+1)
//   out_valid   : pair available
//   out_ready   : predictor accepts the pair
//   pair_cnt    : pairs handed off, wraps
// Modports: master = environment side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface dmv_pair_sequencer_if #(
  parameter int CNT_W = 8
);
  logic                    start;
  logic                    busy;
  logic                    bs_valid;
  logic        [1:0]       bs_bits;
  logic        [1:0]       bs_consume;
  logic signed [1:0]       dmv_h;
  logic signed [1:0]       dmv_v;
  logic                    out_valid;
  logic                    out_ready;
  logic        [CNT_W-1:0] pair_cnt;

  modport master (
    output start, bs_valid, bs_bits, out_ready,
    input  busy, bs_consume, dmv_h, dmv_v, out_valid, pair_cnt
  );

  modport slave (
    input  start, bs_valid, bs_bits, out_ready,
    output busy, bs_consume, dmv_h, dmv_v, out_valid, pair_cnt
  );
endinterface

// File: rtl/dmv_vlc_decode.sv
// ---------------------------------------------------------------------------
// dmv_vlc_decode
// Combinational dmvector VLC decoder.
//   bits   in  2 : next two bitstream bits, bits[1] earliest
//   value  out 2 : signed decoded value ('0'->0, '10'->+1, '11'->-1)
//   length out 2 : code length in bits (1 or 2)
// ---------------------------------------------------------------------------
module dmv_vlc_decode
  import mpeg_mv_pkg::*;
(
  input  logic        [1:0] bits,
  output logic signed [1:0] value,
  output logic        [1:0] length
);

  always_comb begin
    value  = DMV_ZERO;
    length = LEN_SHORT;
    // A leading 1 means a two-bit code; the second bit is the sign.
    if (bits[1]) begin
      length = LEN_LONG;
      value  = bits[0] ? DMV_NEG : DMV_POS;
    end
  end

endmodule

// File: rtl/dmv_pair_sequencer.sv
// ---------------------------------------------------------------------------
// dmv_pair_sequencer
// Decodes one dual-prime dmvector pair (horizontal then vertical) per start
// request, owning the shifter consume handshake, and hands the pair to the
// motion vector predictor over valid/ready.
//   clk : clock
//   rst : synchronous active-high reset
//   bus : dmv_pair_sequencer_if.slave (start, busy, bs_*, dmv_*, out_*,
//         pair_cnt)
// Parameter CNT_W: width of the handed-off pair counter.
// ---------------------------------------------------------------------------
module dmv_pair_sequencer
  import mpeg_mv_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  dmv_pair_sequencer_if.slave  bus
);

  state_t                  r_state;
  state_t                  w_state_next;
  logic                    r_busy;
  logic signed [1:0]       r_dmv_h;
  logic signed [1:0]       r_dmv_v;
  logic        [CNT_W-1:0] r_pair_cnt;

  logic signed [1:0]       w_dec_value;
  logic        [1:0]       w_dec_len;
  logic        [1:0]       w_consume;
  logic                    w_take;
  logic                    w_handoff;

  // One decoder serves both decode states; only one is active at a time.
  dmv_vlc_decode u_decode (
    .bits   (bus.bs_bits),
    .value  (w_dec_value),
    .length (w_dec_len)
  );

  always_comb begin
    w_state_next = r_state;
    w_take       = 1'b0;
    w_handoff    = 1'b0;
    w_consume    = LEN_NONE;
    case (r_state)
      IDLE: begin
        if (bus.start) w_state_next = DEC_H;
      end
      DEC_H: begin
        if (bus.bs_valid) begin
          w_take       = 1'b1;
          w_consume    = w_dec_len;
          w_state_next = DEC_V;
        end
      end
      DEC_V: begin
        if (bus.bs_valid) begin
          w_take       = 1'b1;
          w_consume    = w_dec_len;
          w_state_next = OUT;
        end
      end
      OUT: begin
        // start only counts when the pair is accepted in the same cycle.
        if (bus.out_ready) begin
          w_handoff    = 1'b1;
          w_state_next = bus.start ? DEC_H : IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_busy     <= 1'b0;
      r_dmv_h    <= DMV_ZERO;
      r_dmv_v    <= DMV_ZERO;
      r_pair_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next != IDLE);
      if (w_take && (r_state == DEC_H)) r_dmv_h <= w_dec_value;
      if (w_take && (r_state == DEC_V)) r_dmv_v <= w_dec_value;
      if (w_handoff) r_pair_cnt <= r_pair_cnt + 1'b1;
    end
  end

  assign bus.busy       = r_busy;
  assign bus.out_valid  = (r_state == OUT);
  assign bus.dmv_h      = r_dmv_h;
  assign bus.dmv_v      = r_dmv_v;
  assign bus.pair_cnt   = r_pair_cnt;
  // Gated again by state so the shifter can never advance outside a decode.
  assign bus.bs_consume = is_decode_state(r_state) ? w_consume : LEN_NONE;

endmodule

// File: tb/tb_dmv_pair_sequencer.sv
// ---------------------------------------------------------------------------
// tb_dmv_pair_sequencer
// Directed bench for dmv_pair_sequencer. A bit queue stands in for the
// bitstream shifter and is advanced by whatever the DUT consumes.
// ---------------------------------------------------------------------------
module tb_dmv_pair_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  bit   stream_q[$];

  always #5 clk = ~clk;

  dmv_pair_sequencer_if #(.CNT_W(8)) bus ();

  dmv_pair_sequencer #(.CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh_bits();
    bus.bs_bits[1] = (stream_q.size() > 0) ? stream_q[0] : 1'b0;
    bus.bs_bits[0] = (stream_q.size() > 1) ? stream_q[1] : 1'b0;
  endtask

  // v: 0 -> '0', 1 -> '10', -1 -> '11'
  task automatic push_code(input int v);
    if (v == 0) begin
      stream_q.push_back(1'b0);
    end else begin
      stream_q.push_back(1'b1);
      stream_q.push_back(v < 0);
    end
    refresh_bits();
  endtask

  // One clock: sample consume just before the edge, retire those bits after.
  task automatic tick();
    logic [1:0] cons;
    #1;
    cons = bus.bs_consume;
    @(posedge clk);
    #1;
    for (int k = 0; k < int'(cons); k++)
      if (stream_q.size() > 0) void'(stream_q.pop_front());
    refresh_bits();
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.bs_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.bs_bits   = 2'b00;
    tick();
    tick();
    check("rst_busy", bus.busy, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_consume", bus.bs_consume, 2'd0);
    check("rst_dmv_h", bus.dmv_h, 2'sb00);
    check("rst_dmv_v", bus.dmv_v, 2'sb00);
    check("rst_pair_cnt", bus.pair_cnt, 8'd0);
    rst = 1'b0;
    tick();

    // Basic decode: '0','10'
    push_code(0);
    push_code(1);
    bus.bs_valid = 1'b1;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    check("basic_busy_c1", bus.busy, 1'b1);
    check("basic_consume_h", bus.bs_consume, 2'd1);
    tick();
    check("basic_consume_v", bus.bs_consume, 2'd2);
    check("basic_valid_c2", bus.out_valid, 1'b0);
    tick();
    check("basic_valid_c3", bus.out_valid, 1'b1);
    check("basic_dmv_h", bus.dmv_h, 2'sb00);
    check("basic_dmv_v", bus.dmv_v, 2'sb01);
    check("basic_consume_out", bus.bs_consume, 2'd0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("basic_pair_cnt", bus.pair_cnt, 8'd1);
    check("basic_idle_busy", bus.busy, 1'b0);
    check("basic_idle_valid", bus.out_valid, 1'b0);

    // Negative values with a 2-cycle stall in DEC_V
    push_code(-1);
    push_code(-1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("neg_consume_h", bus.bs_consume, 2'd2);
    tick();
    bus.bs_valid = 1'b0;
    #1;
    check("neg_stall1_consume", bus.bs_consume, 2'd0);
    check("neg_dmv_h", bus.dmv_h, 2'sb11);
    tick();
    check("neg_stall2_consume", bus.bs_consume, 2'd0);
    check("neg_stall2_valid", bus.out_valid, 1'b0);
    tick();
    check("neg_c4_valid", bus.out_valid, 1'b0);
    bus.bs_valid = 1'b1;
    #1;
    check("neg_consume_v", bus.bs_consume, 2'd2);
    tick();
    check("neg_c5_valid", bus.out_valid, 1'b1);
    check("neg_dmv_v", bus.dmv_v, 2'sb11);

    // Backpressure: out_ready low 4 cycles, start pulse ignored
    for (int i = 0; i < 4; i++) begin
      check("bp_valid", bus.out_valid, 1'b1);
      check("bp_dmv_h", bus.dmv_h, 2'sb11);
      check("bp_dmv_v", bus.dmv_v, 2'sb11);
      check("bp_pair_cnt", bus.pair_cnt, 8'd1);
      bus.start = (i == 1);
      tick();
      bus.start = 1'b0;
    end
    check("bp_still_valid", bus.out_valid, 1'b1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("bp_idle_busy", bus.busy, 1'b0);
    check("bp_idle_valid", bus.out_valid, 1'b0);
    check("bp_pair_cnt_done", bus.pair_cnt, 8'd2);

    // Back-to-back: pair A = (0,+1), pair B = (+1,0)
    push_code(0);
    push_code(1);
    push_code(1);
    push_code(0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    check("b2b_a_valid", bus.out_valid, 1'b1);
    check("b2b_a_dmv_v", bus.dmv_v, 2'sb01);
    bus.start     = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;
    check("b2b_busy", bus.busy, 1'b1);
    check("b2b_dech_valid", bus.out_valid, 1'b0);
    check("b2b_pair_cnt", bus.pair_cnt, 8'd3);
    check("b2b_consume_h", bus.bs_consume, 2'd2);
    tick();
    check("b2b_consume_v", bus.bs_consume, 2'd1);
    check("b2b_b_dmv_h", bus.dmv_h, 2'sb01);
    tick();
    check("b2b_b_valid", bus.out_valid, 1'b1);
    check("b2b_b_dmv_v", bus.dmv_v, 2'sb00);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("b2b_pair_cnt_done", bus.pair_cnt, 8'd4);

    // Reset during DEC_V
    push_code(1);
    push_code(-1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check("mid_pre_dmv_h", bus.dmv_h, 2'sb01);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_busy", bus.busy, 1'b0);
    check("mid_valid", bus.out_valid, 1'b0);
    check("mid_dmv_h", bus.dmv_h, 2'sb00);
    check("mid_dmv_v", bus.dmv_v, 2'sb00);
    check("mid_pair_cnt", bus.pair_cnt, 8'd0);
    check("mid_consume", bus.bs_consume, 2'd0);
    stream_q.delete();
    push_code(-1);
    push_code(0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    check("post_valid", bus.out_valid, 1'b1);
    check("post_dmv_h", bus.dmv_h, 2'sb11);
    check("post_dmv_v", bus.dmv_v, 2'sb00);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("post_pair_cnt", bus.pair_cnt, 8'd1);

    // Counter wrap: 255 more pairs brings the total to 256
    for (int p = 0; p < 255; p++) begin
      push_code(0);
      push_code(0);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      if (p == 253) check("wrap_cnt_255", bus.pair_cnt, 8'd255);
    end
    check("wrap_cnt_0", bus.pair_cnt, 8'd0);
    check("wrap_idle_busy", bus.busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmv_pair_sequencer.md
# dmv_pair_sequencer

Controller for MPEG-2 dual-prime motion vector decoding. On a `start` from the macroblock parser, it pulls bits from the bitstream shifter and decodes the horizontal dmvector, then the vertical dmvector. It returns the pair to the motion vector predictor over a valid/ready handshake. It owns the bit-consumption handshake, so the shared shifter is advanced exactly by the dmvector code lengths.

## Interface

Parameters:
- `CNT_W`, default 8: width of the decoded-pair statistics counter.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request to decode one dmvector pair; single-cycle pulse.
- `busy`  out  1: high in every state except IDLE.
- `bs_valid`  in  1: shifter holds at least 2 valid bits.
- `bs_bits`  in  2: next two bitstream bits; `bs_bits[1]` is the earliest bit.
- `bs_consume`  out  2: bits consumed this cycle, 0..2; combinational from state and `bs_bits`.
- `dmv_h`  out  2, signed: horizontal dmvector, -1/0/+1.
- `dmv_v`  out  2, signed: vertical dmvector, -1/0/+1.
- `out_valid`  out  1: pair available.
- `out_ready`  in  1: predictor accepts the pair.
- `pair_cnt`  out  CNT_W: number of pairs handed off; wraps modulo 2^CNT_W.

## Operation

- The FSM has four states: IDLE, DEC_H, DEC_V, OUT.
- **IDLE:** `start` moves the FSM to DEC_H. Otherwise it stays in IDLE.
- **DEC_H:** when `bs_valid` is high, decode the code, register the result into `dmv_h` and go to DEC_V. When `bs_valid` is low, hold the state and drive `bs_consume` = 0.
- **DEC_V:** identical to DEC_H, but the result goes into `dmv_v` and the next state is OUT.
- **OUT:** `out_valid` is high.
  - On `out_ready`, `pair_cnt` increments.
  - If `start` is high in the same cycle, go to DEC_H (back-to-back pair). Otherwise go to IDLE.
- `start` is ignored in DEC_H and DEC_V. It is also ignored in OUT when `out_ready` is low.
- Code table (earliest bit first):
  - `0` decodes to 0, length 1.
  - `10` decodes to +1, length 2.
  - `11` decodes to -1, length 2.
- Arithmetic and widths:
  - Values use 2-bit two's complement: +1 is 2'b01, -1 is 2'b11, 0 is 2'b00.
  - `bs_consume` is nonzero only in DEC_H or DEC_V, and only when `bs_valid` is high.
- `dmv_h` and `dmv_v` hold their last values until overwritten. They are stable for as long as `out_valid` is high.
- Reset values, from any state (including mid-decode): state IDLE, `busy` 0, `out_valid` 0, `bs_consume` 0, `dmv_h` 0, `dmv_v` 0, `pair_cnt` 0.
  - A partially decoded pair is discarded.
  - Bits already consumed are not restored; resynchronising the bitstream is the parser's job.
- `rst` has priority over `start` and over `out_ready`.

## Timing

- Minimum latency with `bs_valid` held high:
  - `start` sampled at edge 0.
  - DEC_H in cycle 1, DEC_V in cycle 2.
  - `out_valid` high in cycle 3.
- Each cycle with `bs_valid` low in DEC_H or DEC_V adds one cycle of latency.
- When the shifter advances:
  - `bs_consume` is valid in the same cycle as the sampled `bs_bits`.
  - The shifter applies it at the next edge.
  - New `bs_bits` are visible in the following cycle.
- Throughput: back-to-back pairs take 3 cycles each (OUT -> DEC_H -> DEC_V -> OUT).
- `busy` is registered and follows the state: it rises in the cycle after `start` is accepted.
- `pair_cnt` updates at the edge where `out_valid` and `out_ready` are both high.

## Structure

- Package `mpeg_mv_pkg` holds:
  - the state enum (IDLE, DEC_H, DEC_V, OUT);
  - the dmvector value constants DMV_ZERO, DMV_POS, DMV_NEG;
  - the code-length constants.
- Sub-module `dmv_vlc_decode` is purely combinational:
  - input: `bits[1:0]`;
  - outputs: signed 2-bit value and 2-bit length;
  - one instance is shared by DEC_H and DEC_V.
- The FSM, output registers and counter live in the top level.

## Test plan

- **Basic decode.** Reset, then `start` with the bitstream `0`,`10` and `bs_valid` always high.
  - `bs_consume` is 1 then 2.
  - In cycle 3: `dmv_h`=0, `dmv_v`=+1, `out_valid`=1.
  - `pair_cnt`=1 after `out_ready`.
- **Negative values with a stall.** Bitstream `11`,`11`; `bs_valid` low for 2 cycles inside DEC_V.
  - `bs_consume` is 0 during the stall.
  - Result is `dmv_h`=-1, `dmv_v`=-1.
  - `out_valid` rises in cycle 5.
- **Backpressure.** Hold `out_ready` low for 4 cycles in OUT, with a `start` pulse during that time.
  - Outputs stay stable and `start` is ignored.
  - When `out_ready` rises, the FSM returns to IDLE.
  - `pair_cnt` increments once.
- **Back-to-back.** `start` together with `out_ready` in OUT.
  - Next state is DEC_H and `busy` stays high.
  - The second pair appears 3 cycles later.
- **Reset mid-operation.** Assert `rst` in DEC_V.
  - Next cycle: IDLE, `busy`=0, `out_valid`=0, `dmv_h`=0, `pair_cnt`=0.
  - A subsequent `start` decodes normally.
- **Counter wrap.** Run 256 pairs with `CNT_W`=8; `pair_cnt` reads 0 after the 256th handoff.
